// File: rtl/w_buf_pkg.sv
// Shared types and helpers for the ping-pong weight buffer.
// Holds the shadow-bank state encoding, the parity function and the lane slicing helper.
package w_buf_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FULL  = 2'd2
    } shadow_st_e;

    // Parity helper takes words up to this width, zero-extended by the caller.
    localparam int unsigned PAR_MAX_WIDTH = 64;

    function automatic logic even_parity(input logic [PAR_MAX_WIDTH-1:0] d);
        return ^d;
    endfunction

    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/w_buf_pingpong_if.sv
// Handshake/bus bundle between the host (DMA + PE array side) and the ping-pong weight buffer.
// master = host side, slave = buffer.
interface w_buf_pingpong_if #(
    parameter int WIDTH      = 32,
    parameter int COL        = 10,
    parameter int ADDR_WIDTH = 4
);
    logic                    wr_valid_i;
    logic [WIDTH-1:0]        wr_data_i;
    logic                    wr_last_i;
    logic                    wr_ready_o;
    logic                    swap_i;
    logic                    swap_ack_o;
    logic                    rd_en_i;
    logic [ADDR_WIDTH-1:0]   rd_addr_i;
    logic [WIDTH*COL-1:0]    rd_data_o;
    logic                    rd_valid_o;
    logic [COL-1:0]          rd_err_o;
    logic                    active_bank_o;
    logic                    active_valid_o;
    logic                    shadow_full_o;

    modport master (
        output wr_valid_i, wr_data_i, wr_last_i, swap_i, rd_en_i, rd_addr_i,
        input  wr_ready_o, swap_ack_o, rd_data_o, rd_valid_o, rd_err_o,
               active_bank_o, active_valid_o, shadow_full_o
    );

    modport slave (
        input  wr_valid_i, wr_data_i, wr_last_i, swap_i, rd_en_i, rd_addr_i,
        output wr_ready_o, swap_ack_o, rd_data_o, rd_valid_o, rd_err_o,
               active_bank_o, active_valid_o, shadow_full_o
    );
endinterface

// File: rtl/w_buf_bank.sv
// One lane of one weight bank: simple dual-port RAM, one write port and one synchronous read port.
// Contents are never reset.
module w_buf_bank #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/w_buf_pingpong.sv
// Ping-pong weight buffer: DMA fills the shadow bank while the PE array reads rows from the active bank.
// Optional per-word even parity when W_BUF_PARITY_EN is defined; otherwise rd_err_o is tied low.
//
// state    | meaning
// ST_EMPTY | shadow bank holds no words of the next set, counter cleared
// ST_LOAD  | shadow bank partially written
// ST_FULL  | shadow bank complete, writes blocked, waiting for swap
module w_buf_pingpong
    import w_buf_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int COL        = 10,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH  = $clog2(DEPTH*COL+1)
) (
    input  logic clk,
    input  logic rst_i,
    w_buf_pingpong_if.slave bus
);

`ifdef W_BUF_PARITY_EN
    localparam int DW = WIDTH + 1;
`else
    localparam int DW = WIDTH;
`endif
    localparam int unsigned TOTAL  = DEPTH * COL;
    localparam int          LANE_W = (COL > 1) ? $clog2(COL) : 1;

    shadow_st_e              state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   row_q, row_d;
    logic [LANE_W-1:0]       lane_q, lane_d;
    logic                    active_bank_q;
    logic                    active_valid_q;
    logic                    swap_ack_q;
    logic                    wr_fire;
    logic                    swap_fire;
    logic                    last_word;
    logic                    rd_in_range;
    logic                    rd_valid_q;
    logic                    rd_in_range_q;
    logic                    rd_bank_q;
    logic                    rd_hit_q;
    logic [DW-1:0]           wr_word;
    logic [DW-1:0]           ram_q [2][COL];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        lane_d    = lane_q;
        wr_fire   = bus.wr_valid_i && (state_q != ST_FULL);
        swap_fire = bus.swap_i && (state_q == ST_FULL);
        last_word = bus.wr_last_i || (cnt_q == CNT_WIDTH'(TOTAL - 1));
        case (state_q)
            ST_EMPTY, ST_LOAD: begin
                if (wr_fire) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (lane_q == LANE_W'(COL - 1)) begin
                        lane_d = '0;
                        row_d  = row_q + ADDR_WIDTH'(1);
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
                    state_d = last_word ? ST_FULL : ST_LOAD;
                end
            end
            ST_FULL: begin
                if (swap_fire) begin
                    state_d = ST_EMPTY;
                    cnt_d   = '0;
                    row_d   = '0;
                    lane_d  = '0;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                cnt_d   = '0;
                row_d   = '0;
                lane_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q        <= ST_EMPTY;
            cnt_q          <= '0;
            row_q          <= '0;
            lane_q         <= '0;
            active_bank_q  <= 1'b0;
            active_valid_q <= 1'b0;
            swap_ack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            lane_q     <= lane_d;
            swap_ack_q <= swap_fire;
            if (swap_fire) begin
                active_bank_q  <= ~active_bank_q;
                active_valid_q <= 1'b1;
            end
        end
    end

    // Widened compare so non-power-of-2 DEPTH rejects the unused upper addresses.
    assign rd_in_range = 32'(bus.rd_addr_i) < 32'(DEPTH);

    // Read bank is captured with the request, so a read issued alongside a swap sees the old bank.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            rd_valid_q    <= 1'b0;
            rd_in_range_q <= 1'b0;
            rd_bank_q     <= 1'b0;
        end else begin
            rd_valid_q    <= bus.rd_en_i && active_valid_q;
            rd_in_range_q <= rd_in_range;
            rd_bank_q     <= active_bank_q;
        end
    end

    assign rd_hit_q = rd_valid_q && rd_in_range_q;

`ifdef W_BUF_PARITY_EN
    assign wr_word = {even_parity(PAR_MAX_WIDTH'(bus.wr_data_i)), bus.wr_data_i};
`else
    assign wr_word = bus.wr_data_i;
`endif

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar l = 0; l < COL; l++) begin : g_lane
            w_buf_bank #(
                .DW    (DW),
                .DEPTH (DEPTH),
                .AW    (ADDR_WIDTH)
            ) u_ram (
                .clk     (clk),
                .wr_en   (wr_fire && (active_bank_q != 1'(b)) && (lane_q == LANE_W'(l))),
                .wr_addr (row_q),
                .wr_data (wr_word),
                .rd_en   (bus.rd_en_i && rd_in_range && (active_bank_q == 1'(b))),
                .rd_addr (bus.rd_addr_i),
                .rd_data (ram_q[b][l])
            );
        end
    end

    for (genvar l = 0; l < COL; l++) begin : g_out
        logic [DW-1:0] word;
        assign word = rd_bank_q ? ram_q[1][l] : ram_q[0][l];
        assign bus.rd_data_o[lane_lsb(l, WIDTH) +: WIDTH] = rd_hit_q ? word[WIDTH-1:0] : '0;
`ifdef W_BUF_PARITY_EN
        assign bus.rd_err_o[l] = rd_hit_q && (^word);
`else
        assign bus.rd_err_o[l] = 1'b0;
`endif
    end

    assign bus.wr_ready_o     = (state_q != ST_FULL);
    assign bus.shadow_full_o  = (state_q == ST_FULL);
    assign bus.swap_ack_o     = swap_ack_q;
    assign bus.rd_valid_o     = rd_valid_q;
    assign bus.active_bank_o  = active_bank_q;
    assign bus.active_valid_o = active_valid_q;

endmodule

// File: tb/tb_w_buf_pingpong.sv
// Bench for w_buf_pingpong: directed load/swap/read scenarios plus a randomized phase,
// all checked every cycle against a bank/row/lane array model of the buffer.
module tb_w_buf_pingpong;
    localparam int W     = 32;
    localparam int D     = 16;
    localparam int C     = 10;
    localparam int AW    = 4;
    localparam int TOTAL = D * C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    w_buf_pingpong_if #(.WIDTH(W), .COL(C), .ADDR_WIDTH(AW)) bus ();
    w_buf_pingpong #(.WIDTH(W), .DEPTH(D), .COL(C)) dut (.clk(clk), .rst_i(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] m_mem   [2][D][C];
    bit           m_known [2][D][C];
    int           m_active = 0;
    int           m_cnt    = 0;
    bit           m_avalid = 0;
    bit           m_full   = 0;
    logic [C-1:0] m_err_row0 = '0;

    task automatic chk(input string tag, input logic [W*C-1:0] obs, input logic [W*C-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: model consumes the inputs present at the edge, outputs checked 1ns later.
    task automatic step();
        logic [W*C-1:0] exp_data, mask;
        logic [C-1:0]   exp_err;
        bit             exp_valid, exp_ack;
        int             a, r, ln;
        @(posedge clk);
        #1;
        exp_data = '0;
        mask     = '1;
        exp_err  = '0;
        exp_ack  = 0;
        exp_valid = 0;
        if (rst) begin
            m_active = 0;
            m_avalid = 0;
            m_full   = 0;
            m_cnt    = 0;
        end else begin
            a = int'(bus.rd_addr_i);
            exp_valid = bus.rd_en_i && m_avalid;
            if (exp_valid && a < D) begin
                for (int l = 0; l < C; l++) begin
                    if (m_known[m_active][a][l]) exp_data[l*W +: W] = m_mem[m_active][a][l];
                    else mask[l*W +: W] = '0;
                end
                if (a == 0) exp_err = m_err_row0;
            end
            exp_ack = bus.swap_i && m_full;
            if (exp_ack) begin
                m_active = 1 - m_active;
                m_avalid = 1;
                m_full   = 0;
                m_cnt    = 0;
            end else if (bus.wr_valid_i && !m_full) begin
                r  = m_cnt / C;
                ln = m_cnt % C;
                m_mem[1-m_active][r][ln]   = bus.wr_data_i;
                m_known[1-m_active][r][ln] = 1;
                m_cnt++;
                if (m_cnt == TOTAL || bus.wr_last_i) m_full = 1;
            end
        end
        chk("rd_data",      bus.rd_data_o & mask, exp_data & mask);
        chk("rd_valid",     bus.rd_valid_o, exp_valid);
        chk("rd_err",       bus.rd_err_o, exp_err);
        chk("swap_ack",     bus.swap_ack_o, exp_ack);
        chk("wr_ready",     bus.wr_ready_o, !m_full);
        chk("shadow_full",  bus.shadow_full_o, m_full);
        chk("active_bank",  bus.active_bank_o, m_active[0]);
        chk("active_valid", bus.active_valid_o, m_avalid);
    endtask

    task automatic idle();
        bus.wr_valid_i = 0;
        bus.wr_data_i  = '0;
        bus.wr_last_i  = 0;
        bus.swap_i     = 0;
        bus.rd_en_i    = 0;
        bus.rd_addr_i  = '0;
    endtask

    task automatic do_swap();
        bit seen = 0;
        bus.swap_i = 1;
        for (int i = 0; i < 4 && !seen; i++) begin
            step();
            seen = bus.swap_ack_o;
        end
        bus.swap_i = 0;
        chk("swap_ack_seen", seen, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        idle();
        rst = 1;
        step();
        step();
        chk("rst_rd_data", bus.rd_data_o, '0);
        chk("rst_wr_ready", bus.wr_ready_o, 1);
        chk("rst_active_valid", bus.active_valid_o, 0);
        rst = 0;
        step();

        // 1: full load of k, swap into bank 1
        for (int k = 0; k < TOTAL; k++) begin
            bus.wr_valid_i = 1;
            bus.wr_data_i  = W'(k);
            step();
        end
        chk("t1_full", bus.shadow_full_o, 1);
        chk("t1_ready", bus.wr_ready_o, 0);
        bus.wr_data_i = 32'hdead_beef;
        step();
        bus.wr_valid_i = 0;
        do_swap();
        chk("t1_active_bank", bus.active_bank_o, 1);

        // 2: read row 3, then idle
        bus.rd_en_i   = 1;
        bus.rd_addr_i = AW'(3);
        step();
        for (int i = 0; i < C; i++) chk("t2_row3_lane", bus.rd_data_o[i*W +: W], W'(30 + i));
        bus.rd_en_i = 0;
        step();
        chk("t2_idle_data", bus.rd_data_o, '0);
        chk("t2_idle_valid", bus.rd_valid_o, 0);

        // 3: continuous reads while loading 0x1000+k with bubbles, then swap
        bus.rd_en_i = 1;
        guard = 0;
        for (int k = 0; k < TOTAL && guard < 2000; guard++) begin
            bus.rd_addr_i  = AW'($urandom_range(0, D-1));
            bus.wr_valid_i = ($urandom_range(0, 3) != 0);
            bus.wr_data_i  = W'(32'h1000 + k);
            step();
            if (bus.wr_valid_i) k++;
        end
        bus.wr_valid_i = 0;
        chk("t3_full", bus.shadow_full_o, 1);
        do_swap();
        for (int i = 0; i < 20; i++) begin
            bus.rd_addr_i = AW'($urandom_range(0, D-1));
            step();
        end
        bus.rd_en_i = 0;

        // 4: short load of 25 words with wr_last, swap, check stale lanes
        for (int k = 0; k < 25; k++) begin
            bus.wr_valid_i = 1;
            bus.wr_data_i  = W'(32'h2000 + k);
            bus.wr_last_i  = (k == 24);
            step();
        end
        bus.wr_valid_i = 0;
        bus.wr_last_i  = 0;
        chk("t4_full", bus.shadow_full_o, 1);
        do_swap();
        bus.rd_en_i   = 1;
        bus.rd_addr_i = AW'(2);
        step();
        for (int i = 0; i < 5; i++) chk("t4_new_lane", bus.rd_data_o[i*W +: W], W'(32'h2000 + 20 + i));
        for (int i = 5; i < C; i++) chk("t4_stale_lane", bus.rd_data_o[i*W +: W], W'(20 + i));
        bus.rd_en_i = 0;

        // random phase
        for (int c = 0; c < 400; c++) begin
            bus.wr_valid_i = ($urandom_range(0, 2) != 0);
            bus.wr_data_i  = W'($urandom());
            bus.wr_last_i  = ($urandom_range(0, 39) == 0);
            bus.rd_en_i    = 1'($urandom_range(0, 1));
            bus.rd_addr_i  = AW'($urandom_range(0, D-1));
            if (!bus.swap_i && $urandom_range(0, 19) == 0) bus.swap_i = 1;
            step();
            if (bus.swap_ack_o) bus.swap_i = 0;
        end
        idle();
        if (m_full) do_swap();

        // 5: reset in the middle of a load
        for (int k = 0; k < 50; k++) begin
            bus.wr_valid_i = 1;
            bus.wr_data_i  = W'(32'h3000 + k);
            step();
        end
        bus.wr_valid_i = 0;
        rst = 1;
        step();
        rst = 0;
        chk("t5_ready", bus.wr_ready_o, 1);
        chk("t5_full", bus.shadow_full_o, 0);
        chk("t5_bank", bus.active_bank_o, 0);
        chk("t5_avalid", bus.active_valid_o, 0);
        chk("t5_ack", bus.swap_ack_o, 0);
        bus.rd_en_i = 1;
        bus.rd_addr_i = '0;
        step();
        chk("t5_read_valid", bus.rd_valid_o, 0);
        chk("t5_read_data", bus.rd_data_o, '0);
        bus.rd_en_i = 0;

        // fresh full load after reset, then read every row
        for (int k = 0; k < TOTAL; k++) begin
            bus.wr_valid_i = 1;
            bus.wr_data_i  = W'($urandom());
            step();
        end
        bus.wr_valid_i = 0;
        do_swap();
        bus.rd_en_i = 1;
        for (int a = 0; a < D; a++) begin
            bus.rd_addr_i = AW'(a);
            step();
        end
        bus.rd_en_i = 0;
        step();

`ifdef W_BUF_PARITY_EN
        // 6: corrupt the stored parity bit of lane 7 row 0 in the active bank
        if (m_active == 0) dut.g_bank[0].g_lane[7].u_ram.mem[0][W] = ~dut.g_bank[0].g_lane[7].u_ram.mem[0][W];
        else               dut.g_bank[1].g_lane[7].u_ram.mem[0][W] = ~dut.g_bank[1].g_lane[7].u_ram.mem[0][W];
        m_err_row0 = 10'b0010000000;
        bus.rd_en_i   = 1;
        bus.rd_addr_i = '0;
        step();
        bus.rd_addr_i = AW'(1);
        step();
        bus.rd_en_i = 0;
        step();
        if (m_active == 0) dut.g_bank[0].g_lane[7].u_ram.mem[0][W] = ~dut.g_bank[0].g_lane[7].u_ram.mem[0][W];
        else               dut.g_bank[1].g_lane[7].u_ram.mem[0][W] = ~dut.g_bank[1].g_lane[7].u_ram.mem[0][W];
        m_err_row0 = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
